// File: rtl/diff_operator_multi.sv
// Cascaded saturating backward-difference operator: lane k of out is the
// k-th order difference of the most recently accepted sample.
module diff_operator_multi #(
  parameter int max_order  = 3,
  parameter int data_width = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic signed [data_width-1:0] y,
  output logic signed [data_width-1:0] out [max_order:1]
);

  typedef logic signed [data_width-1:0] sample_t;

  // One extra bit holds any difference exactly; a sign/overflow bit mismatch means clamp.
  function automatic sample_t subSat(input sample_t a, input sample_t b);
    logic signed [data_width:0] wide;
    wide = {a[data_width-1], a} - {b[data_width-1], b};
    if (wide[data_width] != wide[data_width-1])
      subSat = wide[data_width] ? {1'b1, {(data_width-1){1'b0}}}
                                : {1'b0, {(data_width-1){1'b1}}};
    else
      subSat = wide[data_width-1:0];
  endfunction

  sample_t h_d   [0:max_order-1];
  sample_t h_q   [0:max_order-1];
  sample_t out_d [max_order:1];
  sample_t out_q [max_order:1];

  // The whole cascade settles in one cycle; a running stage value avoids a self-referencing array.
  always_comb begin
    sample_t stage;
    stage = y;
    for (int k = 0; k < max_order; k++) begin
      h_d[k]     = en ? stage : h_q[k];
      stage      = subSat(stage, h_q[k]);
      out_d[k+1] = en ? stage : out_q[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < max_order; k++) begin
        h_q[k]     <= '0;
        out_q[k+1] <= '0;
      end
    end else begin
      for (int k = 0; k < max_order; k++) begin
        h_q[k]     <= h_d[k];
        out_q[k+1] <= out_d[k+1];
      end
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_diff_operator_multi.sv
// Self-checking bench for diff_operator_multi: directed plan steps plus a
// randomized stream, checked against a saturating difference-table model.
module tb_diff_operator_multi;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic signed [15:0] y;
  logic signed [15:0] out1 [1:1];
  logic signed [15:0] out3 [3:1];
  logic signed [15:0] out8 [8:1];

  int checks = 0;
  int errors = 0;

  // Model: prevDiff[k] is the k-th difference at the previous accepted sample
  // (prevDiff[0] is the previous sample); modelOut[k] the last produced k-th difference.
  int prevDiff [0:7];
  int modelOut [1:8];

  always #5 clk = ~clk;

  diff_operator_multi #(.max_order(1), .data_width(16)) dut1 (
    .clk(clk), .reset(reset), .en(en), .y(y), .out(out1));
  diff_operator_multi #(.max_order(3), .data_width(16)) dut3 (
    .clk(clk), .reset(reset), .en(en), .y(y), .out(out3));
  diff_operator_multi #(.max_order(8), .data_width(16)) dut8 (
    .clk(clk), .reset(reset), .en(en), .y(y), .out(out8));

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic modelStep(input logic rst, input logic enable, input int sample);
    int cur [0:8];
    if (rst) begin
      for (int k = 0; k < 8; k++) prevDiff[k] = 0;
      for (int k = 1; k <= 8; k++) modelOut[k] = 0;
    end else if (enable) begin
      cur[0] = sample;
      for (int k = 1; k <= 8; k++) cur[k] = clamp16(cur[k-1] - prevDiff[k-1]);
      for (int k = 0; k < 8; k++) prevDiff[k] = cur[k];
      for (int k = 1; k <= 8; k++) modelOut[k] = cur[k];
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic enable, input int sample);
    reset = rst;
    en    = enable;
    y     = 16'(sample);
    modelStep(rst, enable, sample);
    @(posedge clk);
    #1;
  endtask

  task automatic checkLane(input string tag, input int lane,
                           input logic signed [15:0] got, input int expInt);
    logic signed [15:0] expVal;
    expVal = 16'(expInt);
    checks++;
    assert (got === expVal)
      else begin
        errors++;
        $error("[TB] FAIL %s lane %0d observed %0d expected %0d", tag, lane, got, expVal);
      end
  endtask

  task automatic checkModel(input string tag);
    checkLane({tag, "_o1"}, 1, out1[1], modelOut[1]);
    for (int k = 1; k <= 3; k++) checkLane({tag, "_o3"}, k, out3[k], modelOut[k]);
    for (int k = 1; k <= 8; k++) checkLane({tag, "_o8"}, k, out8[k], modelOut[k]);
  endtask

  task automatic checkOutput(input string tag, input int e1, input int e2, input int e3);
    checkLane(tag, 1, out3[1], e1);
    checkLane(tag, 2, out3[2], e2);
    checkLane(tag, 3, out3[3], e3);
  endtask

  initial begin
    int seqY  [5];
    int seqE1 [5];
    int seqE2 [5];
    int seqE3 [5];
    int binom;

    seqY  = '{1, 4, 7, -5, -3};
    seqE1 = '{1, 3, 3, -12, 2};
    seqE2 = '{1, 2, 0, -15, 14};
    seqE3 = '{1, 1, -2, -15, 29};

    reset = 1'b1;
    en    = 1'b0;
    y     = '0;
    @(negedge clk);

    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("reset", 0, 0, 0);
    checkModel("reset");

    applyStimulus(1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, seqY[i]);
      checkOutput("basic", seqE1[i], seqE2[i], seqE3[i]);
      checkModel("basic");
    end

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 100);
      checkOutput("hold", 2, 14, 29);
    end
    checkModel("hold");

    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 32767);
    checkOutput("satMax", 32767, 32767, 32767);
    applyStimulus(1'b0, 1'b1, -32768);
    checkOutput("satMin", -32768, -32768, -32768);
    checkModel("satMin");
    applyStimulus(1'b0, 1'b1, 32767);
    checkOutput("satBack", 32767, 32767, 32767);
    checkModel("satBack");

    applyStimulus(1'b1, 1'b1, 50);
    checkOutput("rstPrio", 0, 0, 0);
    checkModel("rstPrio");
    applyStimulus(1'b0, 1'b1, 5);
    checkOutput("afterRst", 5, 5, 5);

    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, i);
      if (i == 0)      checkOutput("ramp", 0, 0, 0);
      else if (i == 1) checkOutput("ramp", 1, 1, 1);
      else if (i == 2) checkOutput("ramp", 1, 0, -1);
      else             checkOutput("ramp", 1, 0, 0);
      checkModel("ramp");
    end

    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 10);
    checkLane("order1", 1, out1[1], 10);
    applyStimulus(1'b0, 1'b1, 3);
    checkLane("order1", 1, out1[1], -7);

    applyStimulus(1'b1, 1'b0, 0);
    binom = 1;
    for (int n = 0; n <= 8; n++) begin
      applyStimulus(1'b0, 1'b1, (n == 0) ? 1 : 0);
      checkLane("impulse8", 8, out8[8], (n % 2 == 1) ? -binom : binom);
      checkModel("impulse");
      binom = binom * (8 - n) / (n + 1);
    end

    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 400; i++) begin
      logic rst;
      logic enable;
      int   sample;
      rst    = ($urandom_range(0, 39) == 0);
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        sample = ($urandom_range(0, 1) == 0) ? 32767 - $urandom_range(0, 3)
                                             : -32768 + $urandom_range(0, 3);
      else
        sample = $signed(16'($urandom));
      applyStimulus(rst, enable, sample);
      checkModel("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
